// File: rtl/ws2812b_pixel_encoder_if.sv
// Pixel handshake bundle for the WS2812B encoder.
// Master offers GRB pixels; slave accepts on valid && ready.
interface ws2812b_pixel_encoder_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/ws2812b_pixel_encoder.sv
// WS2812B serialiser: 24-bit GRB pixels in, NRZ pulse-width line out.
// Define WS2812B_TX_SKID_EN to add a one-entry pixel buffer.
module ws2812b_pixel_encoder #(
  parameter int unsigned T0H          = 26,
  parameter int unsigned T1H          = 51,
  parameter int unsigned TBIT         = 80,
  parameter int unsigned RESET_CYCLES = 3840
) (
  input  logic                          clk,
  input  logic                          reset,
  ws2812b_pixel_encoder_if.slave        pix,
  input  logic                          latch,
  output logic                          dout,
  output logic                          busy,
  output logic                          frame_done
);
  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LATCH
  } state_e;

  localparam logic [15:0] T0H_M1 = 16'(T0H - 1);
  localparam logic [15:0] T1H_M1 = 16'(T1H - 1);
  localparam logic [15:0] T0L_M1 = 16'(TBIT - T0H - 1);
  localparam logic [15:0] T1L_M1 = 16'(TBIT - T1H - 1);
  localparam logic [15:0] RST_M1 = 16'(RESET_CYCLES - 1);

  state_e      state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] phase_q, phase_d;
  logic        latch_q, latch_d;
  logic        dout_q;

  logic        acc;
  logic        avail;
  logic        load;
  logic        done;
  logic        buf_full;
  logic [23:0] next_px;
  logic [15:0] th_m1;
  logic [15:0] tl_m1;

  assign acc = pix.pixel_valid && pix.pixel_ready;

`ifdef WS2812B_TX_SKID_EN
  logic        bufv_q, bufv_d;
  logic [23:0] buf_q, buf_d;

  assign pix.pixel_ready = !bufv_q && !reset;
  assign avail           = bufv_q || acc;
  assign next_px         = bufv_q ? buf_q : pix.pixel_data;
  assign buf_full        = bufv_q;

  // A fresh pixel bypasses the buffer when the shifter takes it at once.
  always_comb begin
    bufv_d = bufv_q;
    buf_d  = buf_q;
    if (load && bufv_q) bufv_d = 1'b0;
    if (acc && !load) begin
      bufv_d = 1'b1;
      buf_d  = pix.pixel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bufv_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      bufv_q <= bufv_d;
      buf_q  <= buf_d;
    end
  end
`else
  assign pix.pixel_ready = (state_q == IDLE) && !reset;
  assign avail           = acc;
  assign next_px         = pix.pixel_data;
  assign buf_full        = 1'b0;
`endif

  assign th_m1 = shift_q[23] ? T1H_M1 : T0H_M1;
  assign tl_m1 = shift_q[23] ? T1L_M1 : T0L_M1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    phase_d = phase_q + 16'd1;
    latch_d = latch_q | (latch && (state_q != LATCH));
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (avail) load = 1'b1;
        else if (latch_q) state_d = LATCH;
      end
      HIGH: begin
        if (phase_q == th_m1) begin
          state_d = LOW;
          phase_d = '0;
        end
      end
      LOW: begin
        if (phase_q == tl_m1) begin
          phase_d = '0;
          if (bit_q != 5'd0) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q - 5'd1;
            state_d = HIGH;
          end else if (avail) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LATCH: begin
        if (phase_q == RST_M1) begin
          done    = 1'b1;
          latch_d = 1'b0;
          state_d = IDLE;
          phase_d = '0;
        end
      end
      default: ;
    endcase
    if (load) begin
      shift_d = next_px;
      bit_d   = 5'd23;
      state_d = HIGH;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      latch_q <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      latch_q <= latch_d;
      dout_q  <= (state_d == HIGH);
    end
  end

  assign dout       = dout_q;
  assign busy       = (state_q != IDLE) || latch_q || buf_full;
  assign frame_done = done && !reset;
endmodule

// File: doc/ws2812b_pixel_encoder.md
# ws2812b_pixel_encoder

Transmit-side counterpart of the WS2812B capture path. It accepts 24-bit GRB pixels over a valid/ready handshake, serialises them MSB-first onto a single NRZ pulse-width-coded line, and issues the low "reset/latch" interval on request. It sits between a TinyQV peripheral register front-end and the output PMOD, driving one `dout` wire that can be fanned out to `uo_out`.

## Interface
Parameters:
- `T0H`, default 26: high time of a '0' bit, in clk cycles (0.40 µs at 64 MHz).
- `T1H`, default 51: high time of a '1' bit, in clk cycles (0.80 µs).
- `TBIT`, default 80: full bit period, in clk cycles (1.25 µs). Constraint: 0 < T0H < T1H < TBIT ≤ 65535.
- `RESET_CYCLES`, default 3840: latch low time, in clk cycles (60 µs). Constraint: 1..65535.

Ports:
- `clk` input 1: the single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `pixel_data` input 24: {G[23:16], R[15:8], B[7:0]}, sent bit 23 first.
- `pixel_valid` input 1: `pixel_data` is offered.
- `pixel_ready` output 1: the block accepts `pixel_data` this cycle.
- `latch` input 1: single-cycle request for a latch interval after all accepted pixels are sent.
- `dout` output 1: serial WS2812B line, registered.
- `busy` output 1: high whenever the state is not IDLE or a pixel or latch is pending.
- `frame_done` output 1: one-cycle pulse on the cycle the latch interval completes.

## Operation
- A pixel is accepted on any cycle where `pixel_valid && pixel_ready`. The source must hold `pixel_data` stable while `pixel_valid` is high and not yet accepted.
- FSM states: IDLE, HIGH, LOW, LATCH. Registers: 24-bit shift register, 5-bit bit counter (23..0), 16-bit phase counter, `latch_pend` flag.
- IDLE: `dout`=0.
  - If a pixel is available (accepted this cycle, or held in the buffer when the buffer is configured), load it into the shifter, set bit_cnt=23, and go to HIGH.
  - Otherwise, if `latch_pend` is set, go to LATCH.
- HIGH: `dout`=1 for TH cycles, where TH = T1H if shifter[23] else T0H. Then go to LOW.
- LOW: `dout`=0 for TBIT−TH cycles. At the end of the phase:
  - If bit_cnt≠0: shift left, decrement bit_cnt, go to HIGH.
  - If bit_cnt=0 and the next pixel is available: load it and go to HIGH. No gap.
  - Otherwise go to IDLE.
- LATCH: `dout`=0 for RESET_CYCLES cycles, then clear `latch_pend`, pulse `frame_done`, and go to IDLE.
- `latch` sets `latch_pend` in any state except LATCH; in LATCH it is ignored. A latch is never started while a pixel is in flight or buffered. If a pixel and `latch_pend` are both available in IDLE, the pixel wins.
- `pixel_ready` is combinational from state and buffer and is forced to 0 while `reset` is high.
- Reset mid-frame aborts immediately, with no partial bit completion:
  - state=IDLE, `dout`=0, `busy`=0, `frame_done`=0, `latch_pend`=0, buffer empty.
  - `pixel_ready` is 1 on the first cycle after reset is released.

## Timing
- Pixel accepted in IDLE at cycle N: `dout` rises at N+1.
- Every bit occupies exactly TBIT cycles. A pixel occupies 24·TBIT cycles (1920 with defaults).
- Back-to-back pixels (buffer configured): the first high cycle of the next pixel immediately follows the last low cycle of the previous pixel.
- `latch_pend` with nothing queued in IDLE at cycle N: LATCH from N+1, low for RESET_CYCLES cycles, `frame_done` at N+RESET_CYCLES, IDLE at the next cycle.
- Without the buffer, the inter-pixel gap is exactly 1 IDLE cycle plus the source's response time. This gap is counted as extra low time on the last bit.

## Configuration
- `WS2812B_TX_SKID_EN` defined:
  - Adds a one-entry 24-bit pixel buffer; `pixel_ready` = buffer empty.
  - Acceptance is allowed in any state, including LATCH.
  - The buffer is drained into the shifter in IDLE or at the end of the last LOW phase.
- Not defined:
  - No buffer; `pixel_ready` = (state==IDLE).
  - An accepted pixel loads the shifter directly.
  - "Next pixel available" at the end of LOW is always false.

## Test plan
- Reset release, then pixel 0xFF0000 with default parameters: `dout` shows 8 bits of 51 high/29 low, then 16 bits of 26 high/54 low; `busy` drops after 1920 cycles.
- Pixel 0xA5A5A5, then `latch` one cycle later: the bit pattern matches 1010_0101 ×3; `dout` is low for 3840 cycles after the last bit; `frame_done` pulses exactly once; `busy`=0 on the next cycle.
- With `WS2812B_TX_SKID_EN`, two pixels 0x000001 and 0x800000 offered back-to-back: `pixel_ready` drops after the second accept; the bit 0 low phase (29 cycles) is immediately followed by a 51-cycle high; total 3840 cycles with no gap.
- `latch` and `pixel_valid` asserted together in IDLE: the pixel is sent first; LATCH follows; one `frame_done`.
- `latch` pulsed during LATCH: ignored; only one `frame_done`; IDLE afterwards.
- `reset` asserted mid-bit during HIGH: `dout`=0 on the next cycle; `busy`=0; the pending latch is cleared; `frame_done` never pulses.
